// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: flush-over-stall-over-load, async active-low reset.
// Optional squashed-instruction counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] RD1D,
    input  logic [DATA_W-1:0] RD2D,
    input  logic [DATA_W-1:0] PCD,
    input  logic [DATA_W-1:0] ImmExtD,
    input  logic [DATA_W-1:0] PCPlus4D,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [2:0]        ALUControlD,
    input  logic              ValidD,
    input  logic              FlushE,
    input  logic              StallE,
    output logic [DATA_W-1:0] RD1E,
    output logic [DATA_W-1:0] RD2E,
    output logic [DATA_W-1:0] PCE,
    output logic [DATA_W-1:0] ImmExtE,
    output logic [DATA_W-1:0] PCPlus4E,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [2:0]        ALUControlE,
    output logic              ValidE
`ifdef ID_EX_BUBBLE_CNT_EN
    ,
    output logic [31:0]       BubbleCnt
`endif
);

    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memwrite;
    logic              r_jump;
    logic              r_branch;
    logic              r_alusrc;
    logic [1:0]        r_resultsrc;
    logic [2:0]        r_aluctrl;
    logic              r_valid;

    logic w_load;

    assign w_load = !FlushE && !StallE;

    // A flush zeroes addresses too, so the bubble can never match a forwarding compare.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_jump      <= 1'b0;
            r_branch    <= 1'b0;
            r_alusrc    <= 1'b0;
            r_resultsrc <= '0;
            r_aluctrl   <= '0;
            r_valid     <= 1'b0;
        end else if (FlushE) begin
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_regwrite  <= 1'b0;
            r_memwrite  <= 1'b0;
            r_jump      <= 1'b0;
            r_branch    <= 1'b0;
            r_alusrc    <= 1'b0;
            r_resultsrc <= '0;
            r_aluctrl   <= '0;
            r_valid     <= 1'b0;
        end else if (w_load) begin
            r_rd1       <= RD1D;
            r_rd2       <= RD2D;
            r_pc        <= PCD;
            r_imm       <= ImmExtD;
            r_pc4       <= PCPlus4D;
            r_rs1       <= Rs1D;
            r_rs2       <= Rs2D;
            r_rd        <= RdD;
            r_regwrite  <= RegWriteD;
            r_memwrite  <= MemWriteD;
            r_jump      <= JumpD;
            r_branch    <= BranchD;
            r_alusrc    <= ALUSrcD;
            r_resultsrc <= ResultSrcD;
            r_aluctrl   <= ALUControlD;
            r_valid     <= ValidD;
        end
    end

    assign RD1E        = r_rd1;
    assign RD2E        = r_rd2;
    assign PCE         = r_pc;
    assign ImmExtE     = r_imm;
    assign PCPlus4E    = r_pc4;
    assign Rs1E        = r_rs1;
    assign Rs2E        = r_rs2;
    assign RdE         = r_rd;
    assign RegWriteE   = r_regwrite;
    assign MemWriteE   = r_memwrite;
    assign JumpE       = r_jump;
    assign BranchE     = r_branch;
    assign ALUSrcE     = r_alusrc;
    assign ResultSrcE  = r_resultsrc;
    assign ALUControlE = r_aluctrl;
    assign ValidE      = r_valid;

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic        w_squash;

    assign w_squash = FlushE && ValidD;

    // Saturating: holds at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_bubble_cnt <= '0;
        end else if (w_squash && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign BubbleCnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized self-checking bench for id_ex_reg against a slot-level reference model.
module tb_id_ex_reg;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        regw;
        logic        memw;
        logic        jump;
        logic        branch;
        logic        alusrc;
        logic [1:0]  rsrc;
        logic [2:0]  aluc;
        logic        valid;
    } slot_t;

    logic  clk;
    logic  reset_n;
    logic  flush;
    logic  stall;
    slot_t d;
    slot_t act;
    slot_t exp_slot;
    logic [31:0] exp_cnt;

    logic [31:0] RD1E, RD2E, PCE, ImmExtE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ValidE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt;
`endif

    int unsigned nvec;
    int unsigned nerr;
    logic        chk_en;

    id_ex_reg #(.DATA_W(32), .REG_AW(5)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .RD1D       (d.rd1),
        .RD2D       (d.rd2),
        .PCD        (d.pc),
        .ImmExtD    (d.imm),
        .PCPlus4D   (d.pc4),
        .Rs1D       (d.rs1),
        .Rs2D       (d.rs2),
        .RdD        (d.rd),
        .RegWriteD  (d.regw),
        .MemWriteD  (d.memw),
        .JumpD      (d.jump),
        .BranchD    (d.branch),
        .ALUSrcD    (d.alusrc),
        .ResultSrcD (d.rsrc),
        .ALUControlD(d.aluc),
        .ValidD     (d.valid),
        .FlushE     (flush),
        .StallE     (stall),
        .RD1E       (RD1E),
        .RD2E       (RD2E),
        .PCE        (PCE),
        .ImmExtE    (ImmExtE),
        .PCPlus4E   (PCPlus4E),
        .Rs1E       (Rs1E),
        .Rs2E       (Rs2E),
        .RdE        (RdE),
        .RegWriteE  (RegWriteE),
        .MemWriteE  (MemWriteE),
        .JumpE      (JumpE),
        .BranchE    (BranchE),
        .ALUSrcE    (ALUSrcE),
        .ResultSrcE (ResultSrcE),
        .ALUControlE(ALUControlE),
        .ValidE     (ValidE)
`ifdef ID_EX_BUBBLE_CNT_EN
        ,
        .BubbleCnt  (bubble_cnt)
`endif
    );

    always_comb begin
        act = {RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE,
               RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE,
               ResultSrcE, ALUControlE, ValidE};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Whole-slot compare against the model on every falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if (act !== exp_slot) begin
                nerr++;
                $display("FAIL slot t=%0t got=%h want=%h", $time, act, exp_slot);
            end
`ifdef ID_EX_BUBBLE_CNT_EN
            nvec++;
            if (bubble_cnt !== exp_cnt) begin
                nerr++;
                $display("FAIL bubblecnt t=%0t got=%h want=%h", $time, bubble_cnt, exp_cnt);
            end
`endif
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        nvec++;
        if (got !== want) begin
            nerr++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    function automatic slot_t rnd_slot();
        slot_t s;
        s.rd1    = $urandom;
        s.rd2    = $urandom;
        s.pc     = $urandom;
        s.imm    = $urandom;
        s.pc4    = $urandom;
        s.rs1    = 5'($urandom);
        s.rs2    = 5'($urandom);
        s.rd     = 5'($urandom);
        s.regw   = 1'($urandom);
        s.memw   = 1'($urandom);
        s.jump   = 1'($urandom);
        s.branch = 1'($urandom);
        s.alusrc = 1'($urandom);
        s.rsrc   = 2'($urandom);
        s.aluc   = 3'($urandom);
        s.valid  = 1'($urandom);
        return s;
    endfunction

    // One rising edge: the slot becomes empty on flush, keeps its contents on
    // stall, otherwise becomes the decode slot; squashed real instructions are counted.
    task automatic tick();
        @(posedge clk);
        if (reset_n) begin
            if (flush && d.valid && exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 1;
            if (flush)       exp_slot = '0;
            else if (!stall) exp_slot = d;
        end
        #1;
    endtask

    task automatic async_reset();
        @(negedge clk);
        #2;
        reset_n  = 1'b0;
        exp_slot = '0;
        exp_cnt  = '0;
        #1;
        check("async_rst_slot_lo", act[31:0], 32'h0);
        check("async_rst_rd1", RD1E, 32'h0);
        check("async_rst_valid", {31'h0, ValidE}, 32'h0);
        tick();
        @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        nvec     = 0;
        nerr     = 0;
        chk_en   = 1'b0;
        reset_n  = 1'b0;
        flush    = 1'b0;
        stall    = 1'b0;
        d        = '0;
        exp_slot = '0;
        exp_cnt  = '0;
        #1;
        chk_en = 1'b1;
        check("reset_valid", {31'h0, ValidE}, 32'h0);
        check("reset_rd1", RD1E, 32'h0);
        tick();
        @(negedge clk);
        #1;
        reset_n = 1'b1;

        // Plain load: one edge of latency.
        d       = '0;
        d.rd1   = 32'h1234_5678;
        d.rd    = 5'd7;
        d.regw  = 1'b1;
        d.valid = 1'b1;
        tick();
        check("load_rd1", RD1E, 32'h1234_5678);
        check("load_rd", {27'h0, RdE}, 32'd7);
        check("load_regwrite", {31'h0, RegWriteE}, 32'd1);
        check("load_valid", {31'h0, ValidE}, 32'd1);

        // Stall holds for three edges while decode changes.
        stall = 1'b1;
        d.rd1 = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_rd1", RD1E, 32'h1234_5678);
        end

        // Flush wins over stall.
        flush  = 1'b1;
        d.memw = 1'b1;
        tick();
        check("flush_memwrite", {31'h0, MemWriteE}, 32'h0);
        check("flush_rd", {27'h0, RdE}, 32'h0);
        check("flush_valid", {31'h0, ValidE}, 32'h0);
        check("flush_rd1", RD1E, 32'h0);
        flush = 1'b0;
        stall = 1'b0;

        // Async reset while a valid instruction sits in Execute.
        d = rnd_slot();
        d.valid = 1'b1;
        tick();
        check("pre_rst_valid", {31'h0, ValidE}, 32'd1);
        async_reset();

        // Reset arriving during a stall discards the held slot.
        d = rnd_slot();
        tick();
        stall = 1'b1;
        tick();
        async_reset();
        stall = 1'b0;

`ifdef ID_EX_BUBBLE_CNT_EN
        async_reset();
        flush = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d = rnd_slot();
            d.valid = (i < 4);
            tick();
        end
        flush = 1'b0;
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d = rnd_slot();
            d.valid = 1'b1;
            tick();
        end
        stall = 1'b0;
        check("bubble_count4", bubble_cnt, 32'd4);

        @(negedge clk);
        force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.r_bubble_cnt;
        exp_cnt = 32'hFFFF_FFFF;
        flush   = 1'b1;
        d.valid = 1'b1;
        tick();
        flush = 1'b0;
        check("bubble_saturate", bubble_cnt, 32'hFFFF_FFFF);
`endif

        // Randomized mix of load, stall and flush.
        for (int i = 0; i < 400; i++) begin
            d     = rnd_slot();
            flush = ($urandom_range(0, 99) < 15);
            stall = ($urandom_range(0, 99) < 30);
            tick();
        end
        flush = 1'b0;
        stall = 1'b0;
        tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t got=running want=finished", $time);
        $fatal(1);
    end

endmodule
